// File: rtl/dodge_game_core.sv
// -----------------------------------------------------------------------------
// dodge_game_core
//
// Purpose: the game engine for the falling-bar dodge game. A bar with a gap
// HOLE_W columns wide falls through ROWS rows. The player steers left and
// right and must be inside the gap when the bar reaches the bottom row. A
// safe pass bumps bars_cleared. A miss costs a life. Play starts from IDLE
// on start. Losing the last life parks the engine in OVER until the next
// start. Gap placement comes from a free-running 16-bit Fibonacci LFSR that
// is folded into the legal range 0..COLS-HOLE_W.
//
// Optional feature (macro DODGE_SPEEDUP_EN): every 8th safe clear shortens
// the bar-step divisor by one, down to a floor of 1. Without the macro the
// divisor is the constant STEP_DIV and no divisor register exists.
//
// Ports:
//   gameclk      in   sole clock
//   clr          in   asynchronous active-high reset
//   game_tick    in   one-cycle game-step enable
//   score_tick   in   one-cycle score enable
//   start        in   start/restart pulse (ignored while playing)
//   move_left    in   move player one column left (pulse)
//   move_right   in   move player one column right (pulse)
//   barpos       out  current bar row
//   holepos      out  leftmost gap column
//   plrpos       out  player column
//   lives        out  remaining lives
//   timealive    out  survival score, saturating
//   game_over    out  high in OVER
//   hit          out  one-cycle pulse per life lost
//   bars_cleared out  safe passes, saturating at 255
// -----------------------------------------------------------------------------
module dodge_game_core #(
    parameter int          COLS     = 16,
    parameter int          ROWS     = 12,
    parameter int          HOLE_W   = 3,
    parameter int          LIVES    = 3,
    parameter int          STEP_DIV = 1,
    parameter int          TIME_W   = 16,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                        gameclk,
    input  logic                        clr,
    input  logic                        game_tick,
    input  logic                        score_tick,
    input  logic                        start,
    input  logic                        move_left,
    input  logic                        move_right,
    output logic [$clog2(ROWS)-1:0]     barpos,
    output logic [$clog2(COLS)-1:0]     holepos,
    output logic [$clog2(COLS)-1:0]     plrpos,
    output logic [$clog2(LIVES+1)-1:0]  lives,
    output logic [TIME_W-1:0]           timealive,
    output logic                        game_over,
    output logic                        hit,
    output logic [7:0]                  bars_cleared
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int LW = $clog2(LIVES + 1);
    localparam int DW = $clog2(STEP_DIV + 1);

    localparam logic [CW-1:0] MAXH       = CW'(COLS - HOLE_W);
    localparam logic [CW-1:0] HOLE_SZ    = CW'(HOLE_W);
    localparam logic [CW-1:0] PLR_INIT   = CW'(COLS / 2);
    localparam logic [CW-1:0] COL_MAX    = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX    = RW'(ROWS - 1);
    localparam logic [LW-1:0] LIVES_INIT = LW'(LIVES);
    localparam logic [DW-1:0] DIV_INIT   = DW'(STEP_DIV);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // Map the low LFSR bits onto 0..MAXH. Values past MAXH wrap to the
    // bottom of the range, which keeps the gap fully on the playfield.
    function automatic logic [CW-1:0] fold(input logic [CW-1:0] c);
        if (c <= MAXH) begin
            return c;
        end
        return c - (MAXH + CW'(1));
    endfunction

    function automatic logic [TIME_W-1:0] sat_inc_time(input logic [TIME_W-1:0] v);
        return (&v) ? v : v + TIME_W'(1);
    endfunction

    function automatic logic [7:0] sat_inc_bars(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    state_t          state_q, state_d;
    logic [RW-1:0]   barpos_q, barpos_d;
    logic [CW-1:0]   holepos_q, holepos_d;
    logic [CW-1:0]   plrpos_q, plrpos_d;
    logic [LW-1:0]   lives_q, lives_d;
    logic [TIME_W-1:0] timealive_q, timealive_d;
    logic            hit_q, hit_d;
    logic [7:0]      bars_cleared_q, bars_cleared_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [DW-1:0]   div_cur;
    logic            safe;

`ifdef DODGE_SPEEDUP_EN
    logic [DW-1:0]   div_q, div_d;
    assign div_cur = div_q;
`else
    assign div_cur = DIV_INIT;
`endif

    // The player is judged against the position held before the evaluating
    // edge, so a move on that same cycle lands after the verdict.
    assign safe = (plrpos_q >= holepos_q) && ((plrpos_q - holepos_q) < HOLE_SZ);

    always_comb begin
        state_d        = state_q;
        barpos_d       = barpos_q;
        holepos_d      = holepos_q;
        plrpos_d       = plrpos_q;
        lives_d        = lives_q;
        timealive_d    = timealive_q;
        hit_d          = 1'b0;
        bars_cleared_d = bars_cleared_q;
        cnt_d          = cnt_q;
        lfsr_d         = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`ifdef DODGE_SPEEDUP_EN
        div_d          = div_q;
`endif

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d        = ST_PLAY;
                    lives_d        = LIVES_INIT;
                    barpos_d       = '0;
                    plrpos_d       = PLR_INIT;
                    timealive_d    = '0;
                    bars_cleared_d = '0;
                    cnt_d          = '0;
                    holepos_d      = fold(lfsr_q[CW-1:0]);
`ifdef DODGE_SPEEDUP_EN
                    div_d          = DIV_INIT;
`endif
                end
            end

            ST_PLAY: begin
                if (game_tick) begin
                    if (cnt_q == div_cur - DW'(1)) begin
                        cnt_d = '0;
                        if (barpos_q < ROW_MAX) begin
                            barpos_d = barpos_q + RW'(1);
                        end else begin
                            barpos_d  = '0;
                            holepos_d = fold(lfsr_q[CW-1:0]);
                            if (safe) begin
                                bars_cleared_d = sat_inc_bars(bars_cleared_q);
`ifdef DODGE_SPEEDUP_EN
                                // Low three bits about to wrap: an 8th clear.
                                if ((bars_cleared_q != 8'hFF) && (bars_cleared_q[2:0] == 3'd7)
                                    && (div_q > DW'(1))) begin
                                    div_d = div_q - DW'(1);
                                end
`endif
                            end else begin
                                lives_d = lives_q - LW'(1);
                                hit_d   = 1'b1;
                                if (lives_q == LW'(1)) begin
                                    state_d = ST_OVER;
                                end
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + DW'(1);
                    end
                end

                if (score_tick) begin
                    timealive_d = sat_inc_time(timealive_q);
                end

                if (move_left && !move_right) begin
                    if (plrpos_q != '0) begin
                        plrpos_d = plrpos_q - CW'(1);
                    end
                end else if (move_right && !move_left) begin
                    if (plrpos_q != COL_MAX) begin
                        plrpos_d = plrpos_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge gameclk or posedge clr) begin
        if (clr) begin
            state_q        <= ST_IDLE;
            barpos_q       <= '0;
            holepos_q      <= fold(SEED[CW-1:0]);
            plrpos_q       <= PLR_INIT;
            lives_q        <= LIVES_INIT;
            timealive_q    <= '0;
            hit_q          <= 1'b0;
            bars_cleared_q <= '0;
            cnt_q          <= '0;
            lfsr_q         <= SEED;
`ifdef DODGE_SPEEDUP_EN
            div_q          <= DIV_INIT;
`endif
        end else begin
            state_q        <= state_d;
            barpos_q       <= barpos_d;
            holepos_q      <= holepos_d;
            plrpos_q       <= plrpos_d;
            lives_q        <= lives_d;
            timealive_q    <= timealive_d;
            hit_q          <= hit_d;
            bars_cleared_q <= bars_cleared_d;
            cnt_q          <= cnt_d;
            lfsr_q         <= lfsr_d;
`ifdef DODGE_SPEEDUP_EN
            div_q          <= div_d;
`endif
        end
    end

    assign barpos       = barpos_q;
    assign holepos      = holepos_q;
    assign plrpos       = plrpos_q;
    assign lives        = lives_q;
    assign timealive    = timealive_q;
    assign game_over    = (state_q == ST_OVER);
    assign hit          = hit_q;
    assign bars_cleared = bars_cleared_q;

endmodule

// File: tb/tb_dodge_game_core.sv
// -----------------------------------------------------------------------------
// tb_dodge_game_core
//
// Bench for dodge_game_core. The main instance runs with default parameters
// and is tracked cycle by cycle by a behavioural model whose predictions go
// through a scoreboard queue. A second instance with STEP_DIV=4 is used for
// the bar-step pacing, including the speed-up when DODGE_SPEEDUP_EN is set.
// -----------------------------------------------------------------------------
module tb_dodge_game_core;

    logic gameclk, clr;
    logic game_tick, score_tick, start, move_left, move_right;
    logic [3:0]  barpos, holepos, plrpos;
    logic [1:0]  lives;
    logic [15:0] timealive;
    logic        game_over, hit;
    logic [7:0]  bars_cleared;

    logic g4_tick, g4_start, g4_ml, g4_mr, g4_score;
    logic [3:0]  b4_bar, b4_hole, b4_plr;
    logic [1:0]  b4_lives;
    logic [15:0] b4_time;
    logic        b4_over, b4_hit;
    logic [7:0]  b4_bc;

    int n_chk = 0;
    int n_err = 0;

    dodge_game_core dut (
        .gameclk(gameclk), .clr(clr), .game_tick(game_tick), .score_tick(score_tick),
        .start(start), .move_left(move_left), .move_right(move_right),
        .barpos(barpos), .holepos(holepos), .plrpos(plrpos), .lives(lives),
        .timealive(timealive), .game_over(game_over), .hit(hit),
        .bars_cleared(bars_cleared)
    );

    dodge_game_core #(.STEP_DIV(4)) dut4 (
        .gameclk(gameclk), .clr(clr), .game_tick(g4_tick), .score_tick(g4_score),
        .start(g4_start), .move_left(g4_ml), .move_right(g4_mr),
        .barpos(b4_bar), .holepos(b4_hole), .plrpos(b4_plr), .lives(b4_lives),
        .timealive(b4_time), .game_over(b4_over), .hit(b4_hit),
        .bars_cleared(b4_bc)
    );

    initial gameclk = 1'b0;
    always #5 gameclk = ~gameclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model of the default instance -------------
    int          m_st;   // 0 idle, 1 play, 2 over
    int          m_bar, m_hole, m_plr, m_lives, m_time, m_bc;
    int          m_hit;
    logic [15:0] m_lfsr;

    typedef struct packed {
        logic [31:0] bar, hole, plr, lives, t, over, hit, bc;
    } exp_t;
    exp_t sb_q[$];

    function automatic int mfold(input logic [15:0] x);
        int c;
        c = int'(x[3:0]);
        if (c > 13) c = c - 14;
        return c;
    endfunction

    task automatic model_reset();
        m_st = 0; m_bar = 0; m_plr = 8; m_lives = 3; m_time = 0; m_bc = 0; m_hit = 0;
        m_lfsr = 16'hACE1;
        m_hole = mfold(m_lfsr);
    endtask

    task automatic model_step(input logic gt, input logic st, input logic s,
                              input logic ml, input logic mr);
        logic [15:0] nl;
        int p0;
        nl = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        m_hit = 0;
        if (m_st != 1) begin
            if (s) begin
                m_st = 1; m_lives = 3; m_bar = 0; m_plr = 8; m_time = 0; m_bc = 0;
                m_hole = mfold(m_lfsr);
            end
        end else begin
            p0 = m_plr;
            if (gt) begin
                if (m_bar < 11) m_bar++;
                else begin
                    if (p0 >= m_hole && p0 <= m_hole + 2) begin
                        if (m_bc < 255) m_bc++;
                    end else begin
                        m_lives--;
                        m_hit = 1;
                        if (m_lives == 0) m_st = 2;
                    end
                    m_bar = 0;
                    m_hole = mfold(m_lfsr);
                end
            end
            if (st && m_time < 65535) m_time++;
            if (ml && !mr) begin
                if (m_plr > 0) m_plr--;
            end else if (mr && !ml) begin
                if (m_plr < 15) m_plr++;
            end
        end
        m_lfsr = nl;
    endtask

    // One clock: drive inputs, predict, wait for the edge, compare.
    task automatic cycle(input logic gt, input logic st, input logic s,
                         input logic ml, input logic mr);
        exp_t e;
        game_tick = gt; score_tick = st; start = s; move_left = ml; move_right = mr;
        model_step(gt, st, s, ml, mr);
        e.bar = m_bar; e.hole = m_hole; e.plr = m_plr; e.lives = m_lives;
        e.t = m_time; e.over = (m_st == 2); e.hit = m_hit; e.bc = m_bc;
        sb_q.push_back(e);
        @(posedge gameclk);
        #1;
        e = sb_q.pop_front();
        chk("sb_barpos", barpos, e.bar);
        chk("sb_holepos", holepos, e.hole);
        chk("sb_plrpos", plrpos, e.plr);
        chk("sb_lives", lives, e.lives);
        chk("sb_timealive", timealive, e.t);
        chk("sb_game_over", game_over, e.over);
        chk("sb_hit", hit, e.hit);
        chk("sb_bars_cleared", bars_cleared, e.bc);
        game_tick = 0; score_tick = 0; start = 0; move_left = 0; move_right = 0;
        g4_tick = 0; g4_start = 0; g4_ml = 0; g4_mr = 0;
    endtask

    // Pulse clr between edges and confirm the asynchronous reset values
    // before the following edge.
    task automatic do_clr();
        #2 clr = 1'b1;
        #1;
        chk("rst_barpos", barpos, 0);
        chk("rst_holepos", holepos, 1);
        chk("rst_plrpos", plrpos, 8);
        chk("rst_lives", lives, 3);
        chk("rst_timealive", timealive, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_hit", hit, 0);
        chk("rst_bars_cleared", bars_cleared, 0);
        chk("rst4_barpos", b4_bar, 0);
        chk("rst4_plrpos", b4_plr, 8);
        clr = 1'b0;
        model_reset();
    endtask

    task automatic steer4();
        for (int i = 0; i < 20 && b4_plr != b4_hole; i++) begin
            if (b4_plr < b4_hole) g4_mr = 1'b1;
            else g4_ml = 1'b1;
            cycle(0, 0, 0, 0, 0);
        end
        chk("steer4_on_gap", b4_plr, b4_hole);
    endtask

`ifdef DODGE_SPEEDUP_EN
    localparam int DIV_AFTER = 3;
`else
    localparam int DIV_AFTER = 4;
`endif

    initial begin
        clr = 0; game_tick = 0; score_tick = 0; start = 0; move_left = 0; move_right = 0;
        g4_tick = 0; g4_start = 0; g4_ml = 0; g4_mr = 0; g4_score = 0;
        model_reset();
        do_clr();

        // Six steps left into gap 1..3, then a safe pass; start mid-play ignored.
        cycle(0, 0, 1, 0, 0);
        chk("a_holepos", holepos, 1);
        chk("a_plrpos", plrpos, 8);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 0);
        chk("a_plr_left6", plrpos, 2);
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        chk("a_start_in_play", barpos, 6);
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0);
        chk("a_safe_hit", hit, 0);
        chk("a_safe_lives", lives, 3);
        chk("a_safe_cleared", bars_cleared, 1);
        chk("a_safe_barpos", barpos, 0);

        // No moves: first bar misses column 8.
        do_clr();
        cycle(0, 0, 1, 0, 0);
        for (int i = 1; i <= 11; i++) begin
            cycle(1, 0, 0, 0, 0);
            chk("b_barpos_step", barpos, i);
        end
        cycle(1, 0, 0, 0, 0);
        chk("b_hit", hit, 1);
        chk("b_lives", lives, 2);
        chk("b_barpos_wrap", barpos, 0);
        cycle(0, 0, 0, 0, 0);
        chk("b_hit_pulse", hit, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0);
        chk("b_barpos5", barpos, 5);
        chk("b_lives2", lives, 2);
        do_clr();
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0);
        chk("b_idle_barpos", barpos, 0);
        chk("b_idle_time", timealive, 0);

        // Play to game over with score ticks running, then freeze, then restart.
        cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 800 && m_st != 2; i++) cycle(1, 1, 0, 0, 0);
        chk("c_game_over", game_over, 1);
        chk("c_lives0", lives, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 1, 0);
        cycle(0, 0, 1, 0, 0);
        chk("c_restart_lives", lives, 3);
        chk("c_restart_time", timealive, 0);
        chk("c_restart_over", game_over, 0);

        // Movement limits and the both-pressed case.
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 0);
        chk("d_plr_min", plrpos, 0);
        cycle(0, 0, 0, 1, 0);
        chk("d_plr_min_hold", plrpos, 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 1);
        chk("d_plr_max", plrpos, 15);
        cycle(0, 0, 0, 0, 1);
        chk("d_plr_max_hold", plrpos, 15);
        cycle(0, 0, 0, 1, 1);
        chk("d_plr_both", plrpos, 15);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 1);
        chk("d_plr_both_mid", plrpos, 11);

        // STEP_DIV=4 instance: pacing before and after eight safe clears.
        do_clr();
        g4_start = 1'b1;
        cycle(0, 0, 0, 0, 0);
        steer4();
        for (int t = 1; t <= 8; t++) begin
            g4_tick = 1'b1;
            cycle(0, 0, 0, 0, 0);
            chk("e_pace4", b4_bar, t / 4);
        end
        for (int t = 0; t < 40; t++) begin
            g4_tick = 1'b1;
            cycle(0, 0, 0, 0, 0);
        end
        chk("e_first_clear", b4_bc, 1);
        for (int b = 0; b < 7; b++) begin
            steer4();
            for (int t = 0; t < 48; t++) begin
                g4_tick = 1'b1;
                cycle(0, 0, 0, 0, 0);
            end
        end
        chk("e_cleared8", b4_bc, 8);
        chk("e_lives3", b4_lives, 3);
        chk("e_bar0", b4_bar, 0);
        for (int t = 1; t <= 8; t++) begin
            g4_tick = 1'b1;
            cycle(0, 0, 0, 0, 0);
            chk("e_pace_after", b4_bar, t / DIV_AFTER);
        end
        chk("e_hit4", b4_hit, 0);
        chk("e_over4", b4_over, 0);
        chk("e_time4", b4_time, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
